// File: rtl/operand_result_buffer.sv
// operand_result_buffer: captures operand matrices on a run strobe and collects one result tile per engine
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   run_valid_i         capture strobe for a_i/b_i
//   a_i / a_o           input matrix, element (r,c) at index r*IN_DIM+c
//   b_i / b_o           filter matrix, element (r,c) at index r*FLT_DIM+c
//   res_valid_i         per-engine result valid
//   res_i / res_o       per-engine result tiles, engine k at [k*RES_N*DATA_W +: RES_N*DATA_W]
//   fresh_o             engine k has delivered since the last capture
//   done_capture        one-cycle pulse after a capture
//   active_computation  high while awaiting results
//   all_done            one-cycle pulse after the last engine delivers
//   err_o               sticky protocol error, cleared by a capture
//
// Optional feature macro: OPBUF_CLEAR_ON_RUN_EN (every capture also zeroes all result tiles)
module operand_result_buffer #(
  parameter int DATA_W  = 8,
  parameter int IN_DIM  = 4,
  parameter int FLT_DIM = 3,
  parameter int NUM_ENG = 3,
  parameter int RES_N   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              run_valid_i,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]   a_i,
  input  logic [FLT_DIM*FLT_DIM*DATA_W-1:0] b_i,
  input  logic [NUM_ENG-1:0]                res_valid_i,
  input  logic [NUM_ENG*RES_N*DATA_W-1:0]   res_i,
  output logic [IN_DIM*IN_DIM*DATA_W-1:0]   a_o,
  output logic [FLT_DIM*FLT_DIM*DATA_W-1:0] b_o,
  output logic [NUM_ENG*RES_N*DATA_W-1:0]   res_o,
  output logic [NUM_ENG-1:0]                fresh_o,
  output logic                              done_capture,
  output logic                              active_computation,
  output logic                              all_done,
  output logic                              err_o
);
  localparam int A_W = IN_DIM*IN_DIM*DATA_W;
  localparam int B_W = FLT_DIM*FLT_DIM*DATA_W;
  localparam int T_W = RES_N*DATA_W;
  localparam int R_W = NUM_ENG*T_W;
  typedef enum logic [1:0] {IDLE, ARMED, COMPLETE} state_e;
  state_e             state_q, state_d;
  logic [A_W-1:0]     a_q, a_d;
  logic [B_W-1:0]     b_q, b_d;
  logic [R_W-1:0]     res_q, res_d;
  logic [NUM_ENG-1:0] fresh_q, fresh_d;
  logic               err_q, err_d, done_cap_q, done_cap_d, all_done_q, all_done_d;
  // A run strobe always wins: results arriving in the same cycle are dropped without error.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    fresh_d    = fresh_q;
    err_d      = err_q;
    done_cap_d = 1'b0;
    all_done_d = 1'b0;
    if (run_valid_i) begin
      a_d        = a_i;
      b_d        = b_i;
      fresh_d    = '0;
      err_d      = 1'b0;
      done_cap_d = 1'b1;
      state_d    = ARMED;
`ifdef OPBUF_CLEAR_ON_RUN_EN
      res_d      = '0;
`endif
    end else if (state_q == ARMED) begin
      for (int k = 0; k < NUM_ENG; k++) begin
        if (res_valid_i[k]) begin
          res_d[k*T_W +: T_W] = res_i[k*T_W +: T_W];
          fresh_d[k]          = 1'b1;
          if (fresh_q[k]) err_d = 1'b1;
        end
      end
      if (&fresh_d) begin
        state_d    = COMPLETE;
        all_done_d = 1'b1;
      end
    end else if (|res_valid_i) begin
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      fresh_q    <= '0;
      err_q      <= 1'b0;
      done_cap_q <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      fresh_q    <= fresh_d;
      err_q      <= err_d;
      done_cap_q <= done_cap_d;
      all_done_q <= all_done_d;
    end
  end
  assign a_o                = a_q;
  assign b_o                = b_q;
  assign res_o              = res_q;
  assign fresh_o            = fresh_q;
  assign err_o              = err_q;
  assign done_capture       = done_cap_q;
  assign all_done           = all_done_q;
  assign active_computation = (state_q == ARMED);
endmodule

// File: tb/tb_operand_result_buffer.sv
// tb_operand_result_buffer: table-driven, hand-written and random checks against a reference model
module tb_operand_result_buffer;
  localparam int DW  = 8;
  localparam int ID  = 4;
  localparam int FD  = 3;
  localparam int NE  = 3;
  localparam int RN  = 4;
  localparam int A_W = ID*ID*DW;
  localparam int B_W = FD*FD*DW;
  localparam int T_W = RN*DW;
  localparam int R_W = NE*T_W;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic           reset, run;
  logic [A_W-1:0] a_i, a_o;
  logic [B_W-1:0] b_i, b_o;
  logic [NE-1:0]  v_i, fresh_o;
  logic [R_W-1:0] r_i, res_o;
  logic           done_capture, active_computation, all_done, err_o;
  operand_result_buffer #(.DATA_W(DW), .IN_DIM(ID), .FLT_DIM(FD), .NUM_ENG(NE), .RES_N(RN)) dut (
    .clk(clk), .reset(reset), .run_valid_i(run), .a_i(a_i), .b_i(b_i),
    .res_valid_i(v_i), .res_i(r_i), .a_o(a_o), .b_o(b_o), .res_o(res_o),
    .fresh_o(fresh_o), .done_capture(done_capture), .active_computation(active_computation),
    .all_done(all_done), .err_o(err_o));
  int n_cmp = 0;
  int n_bad = 0;
  logic [A_W-1:0] m_a;
  logic [B_W-1:0] m_b;
  logic [T_W-1:0] m_t[NE];
  bit             m_fresh[NE];
  bit             m_waiting, m_dc, m_ad, m_err;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_a = '0; m_b = '0; m_waiting = 0; m_dc = 0; m_ad = 0; m_err = 0;
    for (int k = 0; k < NE; k++) begin m_t[k] = '0; m_fresh[k] = 0; end
  endtask
  task automatic model_step(input bit r, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                            input logic [NE-1:0] v, input logic [R_W-1:0] res);
    int got;
    m_dc = r;
    m_ad = 0;
    if (r) begin
      m_a = a; m_b = b; m_err = 0; m_waiting = 1;
      for (int k = 0; k < NE; k++) m_fresh[k] = 0;
`ifdef OPBUF_CLEAR_ON_RUN_EN
      for (int k = 0; k < NE; k++) m_t[k] = '0;
`endif
    end else if (m_waiting) begin
      got = 0;
      for (int k = 0; k < NE; k++) begin
        if (v[k]) begin
          if (m_fresh[k]) m_err = 1;
          m_t[k] = res[k*T_W +: T_W];
          m_fresh[k] = 1;
        end
        got += int'(m_fresh[k]);
      end
      if (got == NE) begin m_waiting = 0; m_ad = 1; end
    end else if (v != 0) begin
      m_err = 1;
    end
  endtask
  task automatic check_all();
    logic [R_W-1:0] er;
    logic [NE-1:0]  ef;
    for (int k = 0; k < NE; k++) begin er[k*T_W +: T_W] = m_t[k]; ef[k] = m_fresh[k]; end
    chk("a_o", 256'(a_o), 256'(m_a));
    chk("b_o", 256'(b_o), 256'(m_b));
    chk("res_o", 256'(res_o), 256'(er));
    chk("fresh_o", 256'(fresh_o), 256'(ef));
    chk("done_capture", 256'(done_capture), 256'(m_dc));
    chk("active_computation", 256'(active_computation), 256'(m_waiting));
    chk("all_done", 256'(all_done), 256'(m_ad));
    chk("err_o", 256'(err_o), 256'(m_err));
  endtask
  task automatic cyc(input bit r, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                     input logic [NE-1:0] v, input logic [R_W-1:0] res);
    run = r; a_i = a; b_i = b; v_i = v; r_i = res;
    model_step(r, a, b, v, res);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic async_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    run = 1'b1; v_i = '1; a_i = '1; b_i = '1; r_i = '1;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    run = 1'b0; v_i = '0;
    reset = 1'b1;
  endtask
  typedef struct {
    bit            run;
    logic [NE-1:0] v;
    logic [NE-1:0] fr;
    bit            dc, act, ad, err;
  } vec_t;
  vec_t tbl[16];
  initial begin
    logic [A_W-1:0] pa;
    logic [B_W-1:0] pb;
    logic [R_W-1:0] pr;
    tbl[0]  = '{1, 3'b000, 3'b000, 1, 1, 0, 0};
    tbl[1]  = '{0, 3'b111, 3'b111, 0, 0, 1, 0};
    tbl[2]  = '{0, 3'b000, 3'b111, 0, 0, 0, 0};
    tbl[3]  = '{0, 3'b001, 3'b111, 0, 0, 0, 1};
    tbl[4]  = '{1, 3'b000, 3'b000, 1, 1, 0, 0};
    tbl[5]  = '{1, 3'b000, 3'b000, 1, 1, 0, 0};
    tbl[6]  = '{0, 3'b100, 3'b100, 0, 1, 0, 0};
    tbl[7]  = '{0, 3'b001, 3'b101, 0, 1, 0, 0};
    tbl[8]  = '{0, 3'b010, 3'b111, 0, 0, 1, 0};
    tbl[9]  = '{1, 3'b000, 3'b000, 1, 1, 0, 0};
    tbl[10] = '{0, 3'b001, 3'b001, 0, 1, 0, 0};
    tbl[11] = '{0, 3'b001, 3'b001, 0, 1, 0, 1};
    tbl[12] = '{0, 3'b000, 3'b001, 0, 1, 0, 1};
    tbl[13] = '{1, 3'b010, 3'b000, 1, 1, 0, 0};
    tbl[14] = '{0, 3'b010, 3'b010, 0, 1, 0, 0};
    tbl[15] = '{0, 3'b000, 3'b010, 0, 1, 0, 0};
    reset = 1'b0; run = 1'b0; a_i = '0; b_i = '0; v_i = '0; r_i = '0;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int e = 0; e < ID*ID; e++) pa[e*DW +: DW] = 8'(e + 1 + i*16);
      for (int e = 0; e < FD*FD; e++) pb[e*DW +: DW] = 8'(e + 1 + i*9);
      for (int k = 0; k < NE; k++) pr[k*T_W +: T_W] = {RN{8'((k+1)*17 + i - 1)}};
      cyc(tbl[i].run, pa, pb, tbl[i].v, pr);
      chk($sformatf("tbl%0d_fresh", i), 256'(fresh_o), 256'(tbl[i].fr));
      chk($sformatf("tbl%0d_done_capture", i), 256'(done_capture), 256'(tbl[i].dc));
      chk($sformatf("tbl%0d_active", i), 256'(active_computation), 256'(tbl[i].act));
      chk($sformatf("tbl%0d_all_done", i), 256'(all_done), 256'(tbl[i].ad));
      chk($sformatf("tbl%0d_err", i), 256'(err_o), 256'(tbl[i].err));
      if (i == 0) begin
        chk("plan_a_o", 256'(a_o), 256'(128'h100f0e0d0c0b0a090807060504030201));
        chk("plan_b_o", 256'(b_o), 256'(72'h090807060504030201));
      end
      if (i == 1)
        chk("plan_res_o", 256'(res_o), 256'({{RN{8'h33}}, {RN{8'h22}}, {RN{8'h11}}}));
    end
    async_reset();
    chk("rst_fresh", 256'(fresh_o), 256'(0));
    cyc(0, '0, '0, 3'b001, {R_W{1'b1}});
    chk("idle_res_err", 256'(err_o), 256'(1));
    chk("idle_res_fresh", 256'(fresh_o), 256'(0));
    chk("idle_res_tiles", 256'(res_o), 256'(0));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      pa = {$urandom, $urandom, $urandom, $urandom};
      pb = B_W'({$urandom, $urandom, $urandom});
      pr = {$urandom, $urandom, $urandom};
      cyc($urandom_range(0, 7) == 0, pa, pb,
          ($urandom_range(0, 2) == 0) ? NE'(0) : NE'($urandom_range(0, 7)), pr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/operand_result_buffer.md
# operand_result_buffer

Parametrised successor to the fixed 4x4/3x3 capture memory. It latches one input matrix and one filter matrix on a run strobe and presents them as flattened buses to the compute engines (PE, systolic 3x3, systolic 2x2, ...). It collects one result tile per engine on independent result buses and tracks which engines have delivered. It signals completion when every engine has reported.

## Interface
Parameters:
- DATA_W, 8, element width in bits
- IN_DIM, 4, input matrix is IN_DIM x IN_DIM
- FLT_DIM, 3, filter matrix is FLT_DIM x FLT_DIM
- NUM_ENG, 3, number of result channels (engines)
- RES_N, 4, elements per result tile

Packing rule for every flat bus: element (r,c) of a D-wide matrix sits at index r*D+c, in bits [idx*DATA_W +: DATA_W]. Engine k's tile occupies bits [k*RES_N*DATA_W +: RES_N*DATA_W].

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- run_valid_i  in  1  capture strobe for a_i/b_i
- a_i  in  IN_DIM*IN_DIM*DATA_W  input matrix
- b_i  in  FLT_DIM*FLT_DIM*DATA_W  filter matrix
- res_valid_i  in  NUM_ENG  per-engine result valid (engine done)
- res_i  in  NUM_ENG*RES_N*DATA_W  per-engine result tiles
- a_o  out  IN_DIM*IN_DIM*DATA_W  stored input matrix
- b_o  out  FLT_DIM*FLT_DIM*DATA_W  stored filter matrix
- res_o  out  NUM_ENG*RES_N*DATA_W  stored result tiles
- fresh_o  out  NUM_ENG  engine k has delivered since last capture
- done_capture  out  1  one-cycle pulse after a capture
- active_computation  out  1  high while awaiting results (ARMED)
- all_done  out  1  one-cycle pulse when last engine delivers
- err_o  out  1  sticky protocol error

## Operation
- Reset (reset=0, async): all storage, fresh_o, and all outputs are 0. State is IDLE.
- States: IDLE, ARMED, COMPLETE.
- IDLE:
  - run_valid_i=1 → latch a_i, b_i, clear fresh_o, pulse done_capture, go ARMED.
  - res_valid_i is ignored and sets err_o.
- ARMED:
  - For each k with res_valid_i[k]=1, write tile k and set fresh_o[k].
  - Simultaneous valids on several channels are all accepted in the same cycle, with no arbitration and no loss.
  - res_valid_i[k] while fresh_o[k]=1 → overwrite tile k and set err_o.
  - When the updated fresh mask becomes all ones → go COMPLETE and pulse all_done.
- COMPLETE: results hold. res_valid_i is ignored and sets err_o.
- run_valid_i in ARMED or COMPLETE → recapture, clear fresh_o, pulse done_capture, go/stay ARMED. Any res_valid_i in the same cycle is discarded (run wins) and does not set err_o.
- err_o is cleared by a capture, except that an error detected in the capture cycle itself cannot occur (run wins).
- No arithmetic. Storage is pure copy, width-exact.

## Timing
- Capture latency is 1 cycle: a_o/b_o show new values the cycle after run_valid_i is sampled high.
- done_capture is high for exactly that cycle. A run_valid_i held high for N cycles gives N consecutive captures and N cycles of done_capture.
- Result latency is 1 cycle: res_o and fresh_o update on the edge that samples res_valid_i.
- all_done is high in the cycle after the completing edge, for exactly one cycle. active_computation falls in that same cycle.
- active_computation is high in every cycle the state is ARMED.
- Reset assertion mid-operation clears everything immediately, independent of clk. The first edge after release behaves as IDLE.

## Configuration
- OPBUF_CLEAR_ON_RUN_EN defined: every capture also zeroes all result tiles, so res_o reads 0 until each engine redelivers.
- Undefined: result tiles keep their previous values across captures. Only fresh_o is cleared.

## Test plan
- Reset, then run_valid_i=1 one cycle with a_i elements 1..16 and b_i 1..9 → next cycle a_o/b_o match, done_capture=1 for one cycle, active_computation=1.
- In ARMED, res_valid_i=3'b111 in one cycle with tiles {0x11..}, {0x22..}, {0x33..} → all three stored, fresh_o=3'b111, all_done pulses once, active_computation=0.
- Deliver engines 2, 0, 1 on separate cycles → all_done only after engine 1. fresh_o steps 100, 101, 111. err_o=0.
- Engine 0 delivers twice in ARMED (0x05 then 0x06) → tile 0=0x06, err_o=1 sticky until next run_valid_i.
- run_valid_i and res_valid_i[1] together in ARMED → recapture, fresh_o=0, tile 1 unchanged (or 0 with OPBUF_CLEAR_ON_RUN_EN), err_o=0.
- Assert reset during ARMED with fresh_o=3'b010 → all outputs 0 asynchronously. After release, res_valid_i is ignored and sets err_o.
